// File: rtl/kb_event_queue.sv
// kb_event_queue: PS/2 Set-2 prefix parser feeding a show-ahead event FIFO.
// Each completed scancode sequence becomes one 10-bit event {break, extended, code}.
// Optional feature macro: KB_BREAK_EVENT_EN (defined = break events are queued;
// undefined = F0 sequences are consumed but not queued, and event bit [9] is tied to 0).
module kb_event_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  input  logic                  rd_i,
  input  logic                  clr_ovf_i,
  output logic [9:0]            event_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  ovf_o,
  output logic                  bat_ok_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

`ifdef KB_BREAK_EVENT_EN
  localparam logic BREAK_EN = 1'b1;
`else
  localparam logic BREAK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_SKIP   = 3'd4
  } state_t;

  // Parser state
  state_t      state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic        push;
  logic [9:0]  push_data;
  logic        bat_set;

  // FIFO state
  logic [9:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  bat_ok_q, bat_ok_d;
  logic                  wr_en, rd_en, overflow;
  logic                  empty, full;
  logic [9:0]            head;

  // Parser next-state: advances only when a byte is delivered
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    push      = 1'b0;
    push_data = 10'h000;
    bat_set   = 1'b0;
    if (byte_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          case (byte_i)
            8'hE0: state_d = ST_EXT;
            8'hF0: state_d = ST_BRK;
            8'hE1: begin
              state_d = ST_SKIP;
              skip_d  = 3'd7;
            end
            8'hAA: bat_set = 1'b1;
            // Keyboard acks/echo/resend/error bytes carry no key information
            8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: begin
              push      = 1'b1;
              push_data = {2'b00, byte_i};
            end
          endcase
        end
        ST_EXT: begin
          case (byte_i)
            8'hF0: state_d = ST_EXTBRK;
            8'hE0, 8'hE1: ;
            default: begin
              push      = 1'b1;
              push_data = {2'b01, byte_i};
              state_d   = ST_IDLE;
            end
          endcase
        end
        ST_BRK: begin
          if (byte_i != 8'hE0 && byte_i != 8'hF0) begin
            push      = BREAK_EN;
            push_data = {2'b10, byte_i};
            state_d   = ST_IDLE;
          end
        end
        ST_EXTBRK: begin
          if (byte_i != 8'hE0 && byte_i != 8'hF0) begin
            push      = BREAK_EN;
            push_data = {2'b11, byte_i};
            state_d   = ST_IDLE;
          end
        end
        ST_SKIP: begin
          // The Pause sequence is opaque; its last byte yields a single Pause make
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            skip_d    = 3'd0;
            push      = 1'b1;
            push_data = {2'b01, 8'h77};
            state_d   = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          skip_d  = 3'd0;
        end
      endcase
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // FIFO control: pop is ignored when empty, write allowed when not full or when popping
  always_comb begin
    rd_en    = rd_i & ~empty;
    wr_en    = push & (~full | rd_en);
    overflow = push & full & ~rd_en;
    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CNT_ONE;
    end
    // A new overflow takes precedence over a clear in the same cycle
    ovf_d = ovf_q;
    if (overflow) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
    bat_ok_d = bat_ok_q | bat_set;
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      skip_q   <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      bat_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      bat_ok_q <= bat_ok_d;
    end
  end

  // Event storage: contents need no reset because output is masked while empty
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign event_o  = empty ? 10'h000 : {head[9] & BREAK_EN, head[8:0]};
  assign empty_o  = empty;
  assign full_o   = full;
  assign count_o  = count_q;
  assign ovf_o    = ovf_q;
  assign bat_ok_o = bat_ok_q;

endmodule
